stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control front end for the stopwatch. It debounces the two raw push-buttons (start/stop, lap/reset) and runs the mode state machine. It drives the enable, initialise and latch controls of the 24-bit BCD counter directly downstream (`o_countenb`→`i_countenb`, `o_countinit`→`i_countinit`, `o_latchcount`→`i_latchcount`). It runs in the counter's clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable clock cycles required before a button level change is accepted; legal range 2..65535.
- `i_rtcclk`  in  1  single clock; all flops on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_btn_startstop`  in  1  raw, asynchronous start/stop button, active-high.
- `i_btn_lapreset`  in  1  raw, asynchronous lap/reset button, active-high.
- `o_countenb`  out  1  counter enable; 1 = counter advances.
- `o_countinit`  out  1  one-cycle pulse that clears the counter to 000000.
- `o_latchcount`  out  1  1 = counter output follows the live count; 0 = counter output holds (lap freeze).
- `o_state`  out  2  current state encoding, for LEDs/debug.

## Operation
- Each button path has three stages:
  - a 2-flop synchroniser;
  - a debounce counter;
  - a debounced level with 0→1 edge detect that produces a one-cycle press pulse.
- Releases generate no event.
- Debounce counter behaviour:
  - it counts while the synchronised input differs from the debounced level;
  - it clears on any cycle where they agree;
  - when it reaches `DEBOUNCE_CYCLES` consecutive disagreeing cycles, the debounced level toggles and the counter clears;
  - a glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the level.
- States (`o_state`), each with `countenb` / `latchcount`:
  - IDLE = 00: countenb 0, latchcount 1.
  - RUN = 01: countenb 1, latchcount 1.
  - LAP = 10: countenb 1, latchcount 0.
  - STOP = 11: countenb 0, latchcount 1.
- Transitions (SS = start/stop press, LR = lap/reset press):
  - IDLE: SS→RUN. LR→IDLE and pulse `o_countinit`.
  - RUN: SS→STOP. LR→LAP.
  - LAP: SS→STOP, which releases the freeze. LR→RUN, which releases the freeze; the counter never stops.
  - STOP: SS→RUN. LR→IDLE and pulse `o_countinit`.
- Simultaneous SS and LR press pulses in the same cycle: SS wins and LR is discarded, not queued.
- `o_countinit` is exactly one cycle wide per qualifying LR press, including the IDLE self-loop.
- `o_countenb` and `o_latchcount` are decoded from the state register.
- Reset mid-operation: the state machine, synchronisers, debounce counters and levels all return to reset values immediately. No `o_countinit` pulse is generated; the counter has its own reset.
- A button held high through reset release is seen as a fresh press once it has been stable for `DEBOUNCE_CYCLES` cycles.

## Timing
- Reset values:
  - `o_state` = 00 (IDLE).
  - `o_countenb` = 0.
  - `o_latchcount` = 1.
  - `o_countinit` = 0.
  - Synchroniser flops, debounced levels and debounce counters = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: let edge k be the first rising edge that samples a raw button high, with the button held stable afterwards.
  - Synchroniser output is high after edge k+1.
  - Debounced level goes high after edge k+1+D (D = `DEBOUNCE_CYCLES`).
  - The press pulse is high during the cycle after edge k+1+D.
  - `o_state`, `o_countenb` and `o_latchcount` update at edge k+2+D.
  - `o_countinit` is high from edge k+2+D to edge k+3+D.
- A release followed by a new press needs D stable-low cycles and then D stable-high cycles.
- Minimum spacing between accepted presses on one button is therefore 2D cycles.
- The debounce counter must be at least clog2(D+1) bits wide and must not wrap.

## Structure
- Shared package `stopwatch_pkg`:
  - `state_t` enum with the encodings IDLE/RUN/LAP/STOP above;
  - `DEBOUNCE_CYCLES_DEFAULT = 16`.
- Sub-module `btn_debounce`, parameterised by `DEBOUNCE_CYCLES`:
  - ports: `i_rtcclk`, `i_reset_n`, raw in, debounced level out, press pulse out;
  - instantiated twice.
- Top level holds the state register, the output decode and the `o_countinit` flop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset/idle: assert `i_reset_n`=0 for 3 cycles, then release with buttons low → `o_state`=00, `o_countenb`=0, `o_latchcount`=1, `o_countinit`=0, held for 50 cycles.
- Debounce latency and glitch reject:
  - SS high for 3 cycles, then low → no state change;
  - SS held high → `o_state`=01 and `o_countenb`=1 exactly at edge k+6.
- Full cycle IDLE→RUN→LAP→RUN→STOP→IDLE via SS, LR, LR, SS, LR (press/release, 10 cycles each):
  - observe `o_latchcount`=0 only in LAP;
  - `o_countenb`=1 in RUN/LAP;
  - exactly one `o_countinit` pulse on the final LR.
- Simultaneous press: SS and LR rise on the same edge while in RUN → next state STOP (11), and LR produces no LAP entry afterwards.
- Reset mid-LAP: assert `i_reset_n`=0 asynchronously between clock edges → outputs go to reset values before the next edge, with no `o_countinit` pulse.
- Held through reset: SS high before and after reset release → RUN reached at edge 6 after the first sampling edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control front end.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LAP  = 2'b10,
        STOP = 2'b11
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-flop synchroniser, debounce counter, debounced level
// and a registered one-cycle press pulse on each accepted 0->1 level change.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_rtcclk,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_1;
    logic            sync_2;
    logic [CNT_W-1:0] cnt;
    logic            level;
    logic            press;

    always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= i_btn;
            sync_2 <= sync_1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles;
    // the counter peaks at DEBOUNCE_CYCLES-1 and therefore never wraps.
    always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else if (sync_2 == level) begin
            cnt   <= '0;
            press <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= ~level;
            press <= ~level;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            press <= 1'b0;
        end
    end

    assign o_level = level;
    assign o_press = press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: debounced start/stop and lap/reset buttons drive
// the enable, clear and latch controls of the downstream BCD counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       i_rtcclk,
    input  logic       i_reset_n,
    input  logic       i_btn_startstop,
    input  logic       i_btn_lapreset,
    output logic       o_countenb,
    output logic       o_countinit,
    output logic       o_latchcount,
    output logic [1:0] o_state
);

    logic   ss_press;
    logic   lr_press;
    logic   ss_level_unused;
    logic   lr_level_unused;
    state_t state_q;
    state_t state_d;
    logic   countinit_q;
    logic   countinit_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_startstop (
        .i_rtcclk  (i_rtcclk),
        .i_reset_n (i_reset_n),
        .i_btn     (i_btn_startstop),
        .o_level   (ss_level_unused),
        .o_press   (ss_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lapreset (
        .i_rtcclk  (i_rtcclk),
        .i_reset_n (i_reset_n),
        .i_btn     (i_btn_lapreset),
        .o_level   (lr_level_unused),
        .o_press   (lr_press)
    );

    always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            countinit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            countinit_q <= countinit_d;
        end
    end

    // Start/stop has priority: a coincident lap/reset press is dropped.
    always_comb begin
        state_d     = state_q;
        countinit_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_press) begin
                    state_d = RUN;
                end else if (lr_press) begin
                    countinit_d = 1'b1;
                end
            end
            RUN: begin
                if (ss_press) begin
                    state_d = STOP;
                end else if (lr_press) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (ss_press) begin
                    state_d = STOP;
                end else if (lr_press) begin
                    state_d = RUN;
                end
            end
            STOP: begin
                if (ss_press) begin
                    state_d = RUN;
                end else if (lr_press) begin
                    state_d     = IDLE;
                    countinit_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_state      = state_q;
    assign o_countenb   = (state_q == RUN) || (state_q == LAP);
    assign o_latchcount = (state_q != LAP);
    assign o_countinit  = countinit_q;

endmodule
